// File: rtl/cache_set_mem.sv
// Set-associative line store with lookup, round-robin line fill and a
// set-by-set flush that establishes validity after reset or invalidate.
//
// state | meaning
// FLUSH | clearing valid bits and victim pointer of one set per cycle
// IDLE  | accepting lookups and fill requests
// FILL  | writing incoming words into the chosen victim way
module cache_set_mem #(
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_WIDTH    = 20,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 2,
    parameter int WAYS         = 2
) (
    input  logic                                          i_clock,
    input  logic                                          i_reset,
    input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] i_addr,
    input  logic                                          i_rd,
    input  logic                                          i_fill,
    input  logic                                          i_fill_valid,
    input  logic [DATA_WIDTH-1:0]                         i_fill_data,
    input  logic                                          i_invalidate,
    output logic                                          o_ready,
    output logic                                          o_valid,
    output logic                                          o_hit,
    output logic [DATA_WIDTH-1:0]                         o_data,
    output logic                                          o_fill_done
);

    localparam int SETS   = 2 ** INDEX_WIDTH;
    localparam int LINE   = 2 ** OFFSET_WIDTH;
    localparam int ADDR_W = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;
    localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {FLUSH, IDLE, FILL} state_t;

    state_t                  state;
    logic [INDEX_WIDTH-1:0]  flush_cnt;
    logic [OFFSET_WIDTH-1:0] word_cnt;
    logic [TAG_WIDTH-1:0]    fill_tag;
    logic [INDEX_WIDTH-1:0]  fill_idx;
    logic [PTR_W-1:0]        fill_way;

    logic [WAYS-1:0]         valid_mem [SETS];
    logic [PTR_W-1:0]        ptr_mem   [SETS];
    logic [TAG_WIDTH-1:0]    tag_mem   [SETS][WAYS];
    logic [DATA_WIDTH-1:0]   data_mem  [SETS][WAYS][LINE];

    logic [TAG_WIDTH-1:0]    a_tag;
    logic [INDEX_WIDTH-1:0]  a_idx;
    logic [OFFSET_WIDTH-1:0] a_off;
    logic                    hit_c;
    logic [DATA_WIDTH-1:0]   data_c;
    logic                    flush_we;
    logic                    fill_start;
    logic                    fill_word;
    logic                    fill_last;

    assign a_tag = i_addr[ADDR_W-1 -: TAG_WIDTH];
    assign a_idx = i_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign a_off = i_addr[OFFSET_WIDTH-1:0];

    assign o_ready    = (state == IDLE);
    assign flush_we   = (state == FLUSH);
    assign fill_start = (state == IDLE) && i_fill && !i_invalidate;
    assign fill_word  = (state == FILL) && i_fill_valid && !i_invalidate;
    assign fill_last  = fill_word && (word_cnt == OFFSET_WIDTH'(LINE - 1));

    // Descending scan so the lowest-numbered matching way is the one kept.
    always_comb begin
        hit_c  = 1'b0;
        data_c = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_mem[a_idx][w] && (tag_mem[a_idx][w] == a_tag)) begin
                hit_c  = 1'b1;
                data_c = data_mem[a_idx][w][a_off];
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= FLUSH;
            flush_cnt   <= '0;
            word_cnt    <= '0;
            fill_tag    <= '0;
            fill_idx    <= '0;
            fill_way    <= '0;
            o_valid     <= 1'b0;
            o_hit       <= 1'b0;
            o_data      <= '0;
            o_fill_done <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_hit       <= 1'b0;
            o_data      <= '0;
            o_fill_done <= 1'b0;
            if (i_invalidate) begin
                state     <= FLUSH;
                flush_cnt <= '0;
                word_cnt  <= '0;
            end else begin
                case (state)
                    FLUSH: begin
                        flush_cnt <= flush_cnt + 1'b1;
                        if (flush_cnt == INDEX_WIDTH'(SETS - 1)) begin
                            state <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (i_fill) begin
                            fill_tag <= a_tag;
                            fill_idx <= a_idx;
                            fill_way <= ptr_mem[a_idx];
                            word_cnt <= '0;
                            state    <= FILL;
                        end else if (i_rd) begin
                            o_valid <= 1'b1;
                            o_hit   <= hit_c;
                            o_data  <= data_c;
                        end
                    end
                    FILL: begin
                        if (i_fill_valid) begin
                            word_cnt <= word_cnt + 1'b1;
                            if (word_cnt == OFFSET_WIDTH'(LINE - 1)) begin
                                o_fill_done <= 1'b1;
                                state       <= IDLE;
                            end
                        end
                    end
                    default: state <= FLUSH;
                endcase
            end
        end
    end

    // Storage carries no reset; a line only becomes valid through a completed fill.
    always_ff @(posedge i_clock) begin
        if (flush_we) begin
            valid_mem[flush_cnt] <= '0;
            ptr_mem[flush_cnt]   <= '0;
        end
        if (fill_start) begin
            valid_mem[a_idx][ptr_mem[a_idx]] <= 1'b0;
        end
        if (fill_word) begin
            data_mem[fill_idx][fill_way][word_cnt] <= i_fill_data;
            if (fill_last) begin
                valid_mem[fill_idx][fill_way] <= 1'b1;
                tag_mem[fill_idx][fill_way]   <= fill_tag;
                ptr_mem[fill_idx]             <= (WAYS == 1) ? '0 : fill_way + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_set_mem.sv
// Directed bench for cache_set_mem: flush timing, lookups, fills with gaps,
// replacement, invalidate and reset during a fill.
module tb_cache_set_mem;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic [27:0] i_addr;
    logic        i_rd;
    logic        i_fill;
    logic        i_fill_valid;
    logic [31:0] i_fill_data;
    logic        i_invalidate;
    logic        o_ready;
    logic        o_valid;
    logic        o_hit;
    logic [31:0] o_data;
    logic        o_fill_done;

    int tests = 0;
    int fails = 0;

    cache_set_mem dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_addr       (i_addr),
        .i_rd         (i_rd),
        .i_fill       (i_fill),
        .i_fill_valid (i_fill_valid),
        .i_fill_data  (i_fill_data),
        .i_invalidate (i_invalidate),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .o_hit        (o_hit),
        .o_data       (o_data),
        .o_fill_done  (o_fill_done)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [27:0] mk(input logic [19:0] tag, input logic [5:0] idx,
                                       input logic [1:0] off);
        return {tag, idx, off};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles);
        int n = 0;
        while (!o_ready && n < 200) begin
            step();
            n++;
        end
        check(tag, n, exp_cycles);
    endtask

    task automatic do_read(input string tag, input logic [27:0] addr,
                           input logic exp_hit, input logic [31:0] exp_data);
        i_addr = addr;
        i_rd   = 1'b1;
        step();
        i_rd = 1'b0;
        check({tag, "_valid"}, o_valid, 1);
        check({tag, "_hit"}, o_hit, exp_hit);
        check({tag, "_data"}, o_data, exp_data);
    endtask

    task automatic do_fill(input string tag, input logic [19:0] ftag, input logic [5:0] idx,
                           input logic [31:0] base, input int gap, input logic with_rd);
        int dones = 0;
        i_addr = mk(ftag, idx, 2'd0);
        i_fill = 1'b1;
        i_rd   = with_rd;
        step();
        i_fill = 1'b0;
        i_rd   = 1'b0;
        check({tag, "_busy"}, o_ready, 0);
        if (with_rd) check({tag, "_rd_dropped"}, o_valid, 0);
        for (int w = 0; w < 4; w++) begin
            for (int g = 0; g < gap; g++) begin
                step();
                dones += int'(o_fill_done);
            end
            i_fill_valid = 1'b1;
            i_fill_data  = base + 32'(w);
            step();
            i_fill_valid = 1'b0;
            dones += int'(o_fill_done);
            if (w == 3) check({tag, "_done_last"}, o_fill_done, 1);
        end
        step();
        dones += int'(o_fill_done);
        check({tag, "_done_count"}, dones, 1);
    endtask

    initial begin
        int dones;
        i_reset      = 1'b0;
        i_addr       = '0;
        i_rd         = 1'b0;
        i_fill       = 1'b0;
        i_fill_valid = 1'b0;
        i_fill_data  = '0;
        i_invalidate = 1'b0;
        repeat (3) step();
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_hit", o_hit, 0);
        check("rst_data", o_data, 0);
        check("rst_done", o_fill_done, 0);

        i_reset = 1'b1;
        wait_ready("flush_after_reset", 64);

        do_read("miss_empty", mk(20'hABCDE, 6'd17, 2'd1), 1'b0, 32'h0);
        step();
        check("valid_clears", o_valid, 0);

        do_fill("fill_a", 20'h12345, 6'd5, 32'hA0, 0, 1'b0);
        do_read("hit_a2", mk(20'h12345, 6'd5, 2'd2), 1'b1, 32'hA2);
        do_read("hit_a0", mk(20'h12345, 6'd5, 2'd0), 1'b1, 32'hA0);
        do_read("miss_a_tag", mk(20'h12346, 6'd5, 2'd2), 1'b0, 32'h0);

        do_fill("fill_t1", 20'h1, 6'd7, 32'hB0, 0, 1'b0);
        do_fill("fill_t2", 20'h2, 6'd7, 32'hC0, 0, 1'b0);
        do_fill("fill_t3", 20'h3, 6'd7, 32'hD0, 0, 1'b0);
        do_read("evicted_t1", mk(20'h1, 6'd7, 2'd0), 1'b0, 32'h0);
        do_read("hit_t2", mk(20'h2, 6'd7, 2'd1), 1'b1, 32'hC1);
        do_read("hit_t3", mk(20'h3, 6'd7, 2'd3), 1'b1, 32'hD3);
        do_read("hit_a_kept", mk(20'h12345, 6'd5, 2'd3), 1'b1, 32'hA3);

        do_fill("fill_gap", 20'h55, 6'd9, 32'hE0, 3, 1'b0);
        do_read("hit_gap3", mk(20'h55, 6'd9, 2'd3), 1'b1, 32'hE3);
        do_read("hit_gap1", mk(20'h55, 6'd9, 2'd1), 1'b1, 32'hE1);

        do_fill("fill_rd", 20'h77, 6'd10, 32'hF0, 0, 1'b1);
        do_read("hit_fill_rd", mk(20'h77, 6'd10, 2'd2), 1'b1, 32'hF2);

        // Abort a fill after two words with invalidate.
        dones = 0;
        i_addr = mk(20'h99, 6'd11, 2'd0);
        i_fill = 1'b1;
        step();
        i_fill = 1'b0;
        for (int w = 0; w < 2; w++) begin
            i_fill_valid = 1'b1;
            i_fill_data  = 32'h90 + 32'(w);
            step();
            dones += int'(o_fill_done);
        end
        i_fill_valid = 1'b0;
        i_invalidate = 1'b1;
        i_rd         = 1'b1;
        step();
        i_invalidate = 1'b0;
        i_rd         = 1'b0;
        dones += int'(o_fill_done);
        check("inv_no_rd", o_valid, 0);
        check("inv_busy", o_ready, 0);
        begin
            int n = 0;
            while (!o_ready && n < 200) begin
                step();
                dones += int'(o_fill_done);
                n++;
            end
            check("flush_after_inv", n, 64);
        end
        check("inv_no_done", dones, 0);
        do_read("inv_miss_a", mk(20'h12345, 6'd5, 2'd2), 1'b0, 32'h0);
        do_read("inv_miss_t2", mk(20'h2, 6'd7, 2'd1), 1'b0, 32'h0);
        do_read("inv_miss_gap", mk(20'h55, 6'd9, 2'd3), 1'b0, 32'h0);
        do_read("inv_miss_rd", mk(20'h77, 6'd10, 2'd2), 1'b0, 32'h0);
        do_read("inv_miss_abort", mk(20'h99, 6'd11, 2'd0), 1'b0, 32'h0);

        // Reset pulse in the middle of a fill.
        do_fill("fill_pre_rst", 20'h3, 6'd3, 32'h30, 0, 1'b0);
        do_read("hit_pre_rst", mk(20'h3, 6'd3, 2'd1), 1'b1, 32'h31);
        i_addr = mk(20'h4, 6'd3, 2'd0);
        i_fill = 1'b1;
        step();
        i_fill       = 1'b0;
        i_fill_valid = 1'b1;
        i_fill_data  = 32'h40;
        step();
        i_fill_valid = 1'b0;
        #2 i_reset = 1'b0;
        #1;
        check("midrst_ready", o_ready, 0);
        check("midrst_valid", o_valid, 0);
        check("midrst_hit", o_hit, 0);
        check("midrst_data", o_data, 0);
        check("midrst_done", o_fill_done, 0);
        step();
        i_reset = 1'b1;
        wait_ready("flush_after_midrst", 64);
        do_read("midrst_miss_old", mk(20'h3, 6'd3, 2'd1), 1'b0, 32'h0);
        do_read("midrst_miss_new", mk(20'h4, 6'd3, 2'd0), 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_set_mem.md
CACHE_SET_MEM -- requirements
Module: cache_set_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter TAG_WIDTH, default 20, tag bits per line.
REQ-003 SHALL have parameter INDEX_WIDTH, default 6, set index bits; SETS = 2**INDEX_WIDTH.
REQ-004 SHALL have parameter OFFSET_WIDTH, default 2, word-in-line bits; LINE = 2**OFFSET_WIDTH words.
REQ-005 SHALL have parameter WAYS, default 2, ways per set; legal values are 1, 2 and 4.
REQ-006 SHALL have the port i_clock, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have the port i_reset, input, 1 bit: one clock; reset asynchronous, active-low.
REQ-008 SHALL have the port i_addr, input, TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH bits: word address {tag, index, offset}.
REQ-009 SHALL have the port i_rd, input, 1 bit: lookup request.
REQ-010 SHALL have the port i_fill, input, 1 bit: line-fill start for i_addr.
REQ-011 SHALL have the port i_fill_valid, input, 1 bit: fill word present.
REQ-012 SHALL have the port i_fill_data, input, DATA_WIDTH bits: fill word.
REQ-013 SHALL have the port i_invalidate, input, 1 bit: invalidate-all request.
REQ-014 SHALL have the port o_ready, output, 1 bit: block is IDLE and accepts i_rd or i_fill.
REQ-015 SHALL have the port o_valid, output, 1 bit: lookup result valid.
REQ-016 SHALL have the port o_hit, output, 1 bit: lookup hit.
REQ-017 SHALL have the port o_data, output, DATA_WIDTH bits: hit data.
REQ-018 SHALL have the port o_fill_done, output, 1 bit: one-cycle pulse when a line fill completes.

Function
REQ-019 SHALL store per set and way: valid bit, tag, and LINE data words; per set: a round-robin victim pointer of log2(WAYS) bits (0 bits when WAYS=1).
REQ-020 SHALL implement FSM states FLUSH, IDLE and FILL; o_ready = 1 only in IDLE.
REQ-021 FLUSH SHALL clear the valid bits of all ways and the victim pointer of one set per cycle, set 0 up to SETS-1, then enter IDLE; flush takes exactly SETS cycles.
REQ-022 In IDLE, i_rd=1 SHALL be accepted; on the next cycle o_valid=1, with o_hit=1 iff some way has valid=1 and a matching tag at the addressed index; on a hit, o_data = the word at the offset, otherwise o_data = 0.
REQ-023 When multiple ways match, the lowest-numbered way SHALL win.
REQ-024 o_valid SHALL be 0 in every cycle that does not follow an accepted i_rd; i_rd outside IDLE SHALL be ignored.
REQ-025 In IDLE, i_fill=1 SHALL latch tag and index, select victim = pointer[index], clear that way's valid bit, reset the word counter to 0, and enter FILL.
REQ-026 When i_fill and i_rd are both high in IDLE, the fill SHALL be taken and the read dropped (o_valid stays 0).
REQ-027 In FILL, each cycle with i_fill_valid=1 SHALL write i_fill_data to word[counter] of the victim way and increment the counter; cycles with i_fill_valid=0 SHALL stall without a write.
REQ-028 On the word with counter = LINE-1, the block SHALL set valid and tag, increment pointer[index] modulo WAYS, pulse o_fill_done for one cycle, and enter IDLE.
REQ-029 i_fill_valid outside FILL and i_fill outside IDLE SHALL be ignored.
REQ-030 i_invalidate=1 in any state SHALL enter FLUSH at set 0; an in-progress fill is aborted, its victim stays invalid, and no o_fill_done is produced.
REQ-031 i_invalidate SHALL take priority over simultaneous i_rd and i_fill.

Reset
REQ-032 i_reset low SHALL asynchronously force: state FLUSH, flush counter 0, fill counter 0, o_ready=0, o_valid=0, o_hit=0, o_data=0, o_fill_done=0.
REQ-033 Data and tag arrays SHALL NOT require reset; validity is established only by FLUSH.
REQ-034 Reset asserted mid-FILL SHALL discard the fill; after release, the block flushes for SETS cycles before o_ready=1.

Verification
REQ-035 Release reset with defaults -> o_ready=0 for 64 cycles, then o_ready=1; i_rd to any address -> o_valid=1, o_hit=0, o_data=0 one cycle later.
REQ-036 Fill addr tag=0x12345, index=5 with words 0xA0..0xA3 -> o_fill_done pulses on the 4th word; i_rd at offset 2 -> o_hit=1, o_data=0xA2.
REQ-037 Fill tag 0x1, tag 0x2 and then tag 0x3 into index 7 (2 ways) -> tag 0x1 misses, tags 0x2 and 0x3 hit.
REQ-038 Fill with i_fill_valid gaps of 3 cycles between words -> data correct; o_fill_done exactly once, after the last word.
REQ-039 i_invalidate after 2 fill words -> no o_fill_done, 64 flush cycles, every previously filled line misses.
REQ-040 i_fill and i_rd high in the same IDLE cycle -> no o_valid; the fill proceeds; i_reset pulse mid-FILL -> all outputs 0 immediately, then a full flush.
